// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and store/alignment helpers for the memory-stage load/store unit.
package mem_access_unit_pkg;

  // Store size codes produced by the decoder (MemWrite)
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_SB   = 2'b01;
  localparam logic [1:0] MW_SH   = 2'b10;
  localparam logic [1:0] MW_SW   = 2'b11;

  // Load size/sign codes produced by the decoder (Mask); 101-111 behave as LW
  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // FSM state codes
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  // Byte write enables, big-endian: bit 3 is byte offset 0
  function automatic logic [3:0] store_we(input logic [1:0] mw, input logic [1:0] off);
    case (mw)
      MW_SB:   store_we = 4'b1000 >> off;
      MW_SH:   store_we = off[1] ? 4'b0011 : 4'b1100;
      MW_SW:   store_we = 4'b1111;
      default: store_we = 4'b0000;
    endcase
  endfunction

  // Replicate the right-justified store value across every lane it may land in
  function automatic logic [31:0] store_wdata(input logic [1:0] mw, input logic [31:0] sd);
    case (mw)
      MW_SB:   store_wdata = {4{sd[7:0]}};
      MW_SH:   store_wdata = {2{sd[15:0]}};
      MW_SW:   store_wdata = sd;
      default: store_wdata = 32'h0;
    endcase
  endfunction

  // Halfwords need an even offset, words a zero offset; bytes are always aligned
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [1:0] mw,
                                         input logic [2:0] mask,
                                         input logic [1:0] off);
    if (is_store) begin
      case (mw)
        MW_SH:   is_misaligned = off[0];
        MW_SW:   is_misaligned = (off != 2'b00);
        default: is_misaligned = 1'b0;
      endcase
    end else begin
      case (mask)
        LD_B, LD_BU: is_misaligned = 1'b0;
        LD_H, LD_HU: is_misaligned = off[0];
        default:     is_misaligned = (off != 2'b00);
      endcase
    end
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request / data-memory port bundle of the load/store unit.
// slave: the load/store unit itself; master: the surrounding pipeline and memory.
interface mem_access_unit_if;
  // pipeline side
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  MemWrite;
  logic [2:0]  Mask;
  logic        is_load;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic        misalign;
  logic        stall;
  // data-memory side
  logic        dmem_req;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport slave (
    input  req_valid, MemWrite, Mask, is_load, addr, store_data,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output req_ready, load_valid, load_data, misalign, stall,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata
  );

  modport master (
    output req_valid, MemWrite, Mask, is_load, addr, store_data,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  req_ready, load_valid, load_data, misalign, stall,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata
  );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Combinational load extraction: picks the addressed byte/half of a big-endian
// word and sign- or zero-extends it. Shared with any future cache read path.
module load_extract
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  mask,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the addressed lane, then extend according to the load type
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    byte_sel = rdata[31:24];
    half_sel = rdata[31:16];
    data     = rdata;
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    case (offset)
      2'd0:    half_sel = rdata[31:16];
      2'd1:    half_sel = rdata[23:8];
      default: half_sel = rdata[15:0];
    endcase
    case (mask)
      LD_B:    data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data = {24'h0, byte_sel};
      LD_H:    data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: formats stores, checks alignment, runs the
// grant/response handshake with data memory and returns extended load data.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  logic [1:0]  state;
  logic        is_store_r;
  logic [2:0]  mask_r;
  logic [1:0]  off_r;
  logic [3:0]  we_r;
  logic [29:0] waddr_r;
  logic [31:0] wdata_r;
  logic        load_valid_r;
  logic [31:0] load_data_r;
  logic        misalign_r;

  logic        is_store;
  logic        is_access;
  logic        mis;
  logic [31:0] ext_data;

  // Classify the incoming request: a store wins over is_load, neither is a no-op
  always_comb begin
    is_store  = (bus.MemWrite != MW_NONE);
    is_access = is_store || bus.is_load;
    mis       = is_misaligned(is_store, bus.MemWrite, bus.Mask, bus.addr[1:0]);
  end

  load_extract u_extract (
    .rdata  (bus.dmem_rdata),
    .offset (off_r),
    .mask   (mask_r),
    .data   (ext_data)
  );

  // Access FSM with request capture, memory handshake and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      is_store_r   <= 1'b0;
      mask_r       <= LD_B;
      off_r        <= 2'b00;
      we_r         <= 4'b0000;
      waddr_r      <= 30'h0;
      wdata_r      <= 32'h0;
      load_valid_r <= 1'b0;
      load_data_r  <= 32'h0;
      misalign_r   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here update from pre-edge values, independent of statement order.
      load_valid_r <= 1'b0;
      misalign_r   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid && is_access) begin
            if (mis) begin
              misalign_r <= 1'b1;
            end else begin
              state      <= ST_REQ;
              is_store_r <= is_store;
              mask_r     <= bus.Mask;
              off_r      <= bus.addr[1:0];
              waddr_r    <= bus.addr[31:2];
              we_r       <= store_we(bus.MemWrite, bus.addr[1:0]);
              wdata_r    <= store_wdata(bus.MemWrite, bus.store_data);
            end
          end
        end
        ST_REQ: begin
          if (bus.dmem_gnt) begin
            state <= is_store_r ? ST_IDLE : ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.dmem_rvalid) begin
            load_data_r  <= ext_data;
            load_valid_r <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.stall      = (state != ST_IDLE);
  assign bus.dmem_req   = (state == ST_REQ);
  assign bus.dmem_we    = we_r;
  assign bus.dmem_addr  = waddr_r;
  assign bus.dmem_wdata = wdata_r;
  assign bus.load_valid = load_valid_r;
  assign bus.load_data  = load_data_r;
  assign bus.misalign   = misalign_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: stores, loads, misalignment, stalls, reset.
module tb_mem_access_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] mw, input logic [2:0] mask, input logic ld,
                           input logic [31:0] a, input logic [31:0] sd);
    bus.req_valid  = 1'b1;
    bus.MemWrite   = mw;
    bus.Mask       = mask;
    bus.is_load    = ld;
    bus.addr       = a;
    bus.store_data = sd;
  endtask

  task automatic idle_req();
    bus.req_valid = 1'b0;
    bus.MemWrite  = 2'b00;
    bus.is_load   = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_dmem_req got %b want 0", bus.dmem_req); end
    checks++; if (bus.dmem_we !== 4'b0000) begin errors++; $display("FAIL rst_dmem_we got %b want 0000", bus.dmem_we); end
    checks++; if (bus.dmem_addr !== 30'h0) begin errors++; $display("FAIL rst_dmem_addr got %h want 0", bus.dmem_addr); end
    checks++; if (bus.dmem_wdata !== 32'h0) begin errors++; $display("FAIL rst_dmem_wdata got %h want 0", bus.dmem_wdata); end
    checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL rst_load_valid got %b want 0", bus.load_valid); end
    checks++; if (bus.load_data !== 32'h0) begin errors++; $display("FAIL rst_load_data got %h want 0", bus.load_data); end
    checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got %b want 0", bus.misalign); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", bus.stall); end
  endtask

  task automatic test_store();
    logic [1:0]  mw_v [6] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b01};
    logic        ld_v [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] a_v  [6] = '{32'h1003, 32'h1000, 32'h1002, 32'h1000, 32'h2000, 32'h3001};
    logic [31:0] sd_v [6] = '{32'h000000AB, 32'h5566_7712, 32'h1234_CDEF, 32'h0000_BEEF,
                              32'hDEAD_BEEF, 32'hFFFF_FF3C};
    logic [3:0]  we_v [6] = '{4'b0001, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0100};
    logic [31:0] wd_v [6] = '{32'hABABABAB, 32'h12121212, 32'hCDEFCDEF, 32'hBEEFBEEF,
                              32'hDEADBEEF, 32'h3C3C3C3C};
    logic [29:0] wa_v [6] = '{30'h400, 30'h400, 30'h400, 30'h400, 30'h800, 30'hC00};
    for (int i = 0; i < 6; i++) begin
      drive_req(mw_v[i], 3'b010, ld_v[i], a_v[i], sd_v[i]);
      tick();
      idle_req();
      bus.dmem_gnt = 1'b1;
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL st%0d_req got %b want 1", i, bus.dmem_req); end
      checks++; if (bus.dmem_we !== we_v[i]) begin errors++; $display("FAIL st%0d_we got %b want %b", i, bus.dmem_we, we_v[i]); end
      checks++; if (bus.dmem_wdata !== wd_v[i]) begin errors++; $display("FAIL st%0d_wdata got %h want %h", i, bus.dmem_wdata, wd_v[i]); end
      checks++; if (bus.dmem_addr !== wa_v[i]) begin errors++; $display("FAIL st%0d_addr got %h want %h", i, bus.dmem_addr, wa_v[i]); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL st%0d_stall got %b want 1", i, bus.stall); end
      tick();
      bus.dmem_gnt = 1'b0;
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL st%0d_done_req got %b want 0", i, bus.dmem_req); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL st%0d_done_ready got %b want 1", i, bus.req_ready); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL st%0d_done_stall got %b want 0", i, bus.stall); end
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  mk_v [8] = '{3'b000, 3'b011, 3'b001, 3'b100, 3'b010, 3'b111, 3'b000, 3'b001};
    logic [31:0] a_v  [8] = '{32'h2001, 32'h2001, 32'h2002, 32'h2002, 32'h2000, 32'h2000,
                              32'h2003, 32'h2000};
    logic [31:0] rd_v [8] = '{32'h1280_3456, 32'h1280_3456, 32'h0000_8001, 32'h0000_8001,
                              32'h0000_8001, 32'h89AB_CDEF, 32'h0000_00F0, 32'h7FFF_0000};
    logic [31:0] ex_v [8] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001,
                              32'h00008001, 32'h89ABCDEF, 32'hFFFFFFF0, 32'h00007FFF};
    for (int i = 0; i < 8; i++) begin
      drive_req(2'b00, mk_v[i], 1'b1, a_v[i], 32'hFFFF_FFFF);
      tick();
      idle_req();
      bus.dmem_gnt = 1'b1;
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL ld%0d_req got %b want 1", i, bus.dmem_req); end
      checks++; if (bus.dmem_we !== 4'b0000) begin errors++; $display("FAIL ld%0d_we got %b want 0000", i, bus.dmem_we); end
      checks++; if (bus.dmem_addr !== 30'h800) begin errors++; $display("FAIL ld%0d_addr got %h want 800", i, bus.dmem_addr); end
      tick();
      bus.dmem_gnt    = 1'b0;
      bus.dmem_rvalid = 1'b1;
      bus.dmem_rdata  = rd_v[i];
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL ld%0d_resp_req got %b want 0", i, bus.dmem_req); end
      checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_early_valid got %b want 0", i, bus.load_valid); end
      tick();
      bus.dmem_rvalid = 1'b0;
      bus.dmem_rdata  = 32'h0;
      checks++; if (bus.load_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_valid got %b want 1", i, bus.load_valid); end
      checks++; if (bus.load_data !== ex_v[i]) begin errors++; $display("FAIL ld%0d_data got %h want %h", i, bus.load_data, ex_v[i]); end
      tick();
      checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_pulse got %b want 0", i, bus.load_valid); end
      checks++; if (bus.load_data !== ex_v[i]) begin errors++; $display("FAIL ld%0d_hold got %h want %h", i, bus.load_data, ex_v[i]); end
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  mw_v [4] = '{2'b11, 2'b00, 2'b10, 2'b00};
    logic [2:0]  mk_v [4] = '{3'b010, 3'b001, 3'b010, 3'b010};
    logic [31:0] a_v  [4] = '{32'h2002, 32'h2001, 32'h2003, 32'h2001};
    for (int i = 0; i < 4; i++) begin
      drive_req(mw_v[i], mk_v[i], mw_v[i] == 2'b00, a_v[i], 32'h1234_5678);
      tick();
      idle_req();
      checks++; if (bus.misalign !== 1'b1) begin errors++; $display("FAIL mis%0d_pulse got %b want 1", i, bus.misalign); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req got %b want 0", i, bus.dmem_req); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL mis%0d_ready got %b want 1", i, bus.req_ready); end
      tick();
      checks++; if (bus.misalign !== 1'b0) begin errors++; $display("FAIL mis%0d_end got %b want 0", i, bus.misalign); end
      checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL mis%0d_req2 got %b want 0", i, bus.dmem_req); end
    end
  endtask

  task automatic test_back_to_back();
    drive_req(2'b00, 3'b011, 1'b1, 32'h4002, 32'h0);
    tick();
    idle_req();
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hAABB_CCDD;
    tick();
    bus.dmem_rvalid = 1'b0;
    checks++; if (bus.load_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", bus.load_valid); end
    checks++; if (bus.load_data !== 32'h000000CC) begin errors++; $display("FAIL b2b_data got %h want 000000cc", bus.load_data); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.req_ready); end
    drive_req(2'b01, 3'b010, 1'b0, 32'h5002, 32'h0000_0077);
    tick();
    idle_req();
    bus.dmem_gnt = 1'b1;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_st_req got %b want 1", bus.dmem_req); end
    checks++; if (bus.dmem_we !== 4'b0010) begin errors++; $display("FAIL b2b_st_we got %b want 0010", bus.dmem_we); end
    tick();
    bus.dmem_gnt = 1'b0;
  endtask

  task automatic test_noop();
    drive_req(2'b00, 3'b010, 1'b0, 32'h7000, 32'hFFFF_FFFF);
    tick();
    idle_req();
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL noop_req got %b want 0", bus.dmem_req); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL noop_stall got %b want 0", bus.stall); end
    checks++; if (bus.dmem_addr !== 30'h1400) begin errors++; $display("FAIL noop_addr got %h want 1400", bus.dmem_addr); end
    checks++; if (bus.dmem_wdata !== 32'h77777777) begin errors++; $display("FAIL noop_wdata got %h want 77777777", bus.dmem_wdata); end
  endtask

  task automatic test_delayed_grant();
    drive_req(2'b00, 3'b010, 1'b1, 32'h3000, 32'h0);
    tick();
    idle_req();
    for (int c = 1; c <= 4; c++) begin
      checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL dly%0d_req got %b want 1", c, bus.dmem_req); end
      checks++; if (bus.dmem_addr !== 30'hC00) begin errors++; $display("FAIL dly%0d_addr got %h want c00", c, bus.dmem_addr); end
      checks++; if (bus.dmem_we !== 4'b0000) begin errors++; $display("FAIL dly%0d_we got %b want 0000", c, bus.dmem_we); end
      checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL dly%0d_stall got %b want 1", c, bus.stall); end
      tick();
    end
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBAD0_BAD0;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL dly_gnt_req got %b want 1", bus.dmem_req); end
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    checks++; if (bus.dmem_req !== 1'b0) begin errors++; $display("FAIL dly_resp_req got %b want 0", bus.dmem_req); end
    checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL dly_early_valid got %b want 0", bus.load_valid); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL dly_resp_stall got %b want 1", bus.stall); end
    tick();
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1122_3344;
    checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL dly_wait_valid got %b want 0", bus.load_valid); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL dly_wait_stall got %b want 1", bus.stall); end
    tick();
    bus.dmem_rvalid = 1'b0;
    checks++; if (bus.load_valid !== 1'b1) begin errors++; $display("FAIL dly_valid got %b want 1", bus.load_valid); end
    checks++; if (bus.load_data !== 32'h11223344) begin errors++; $display("FAIL dly_data got %h want 11223344", bus.load_data); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL dly_end_stall got %b want 0", bus.stall); end
  endtask

  task automatic test_reset_mid();
    drive_req(2'b00, 3'b010, 1'b1, 32'h6000, 32'h0);
    tick();
    idle_req();
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL rm_in_resp got %b want 1", bus.stall); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rm_stall got %b want 0", bus.stall); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.dmem_addr !== 30'h0) begin errors++; $display("FAIL rm_addr got %h want 0", bus.dmem_addr); end
    checks++; if (bus.load_data !== 32'h0) begin errors++; $display("FAIL rm_data got %h want 0", bus.load_data); end
    tick();
    rst_n           = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rdata  = 32'hCAFE_F00D;
    tick();
    bus.dmem_rvalid = 1'b0;
    bus.dmem_gnt    = 1'b0;
    checks++; if (bus.load_valid !== 1'b0) begin errors++; $display("FAIL rm_no_valid got %b want 0", bus.load_valid); end
    checks++; if (bus.load_data !== 32'h0) begin errors++; $display("FAIL rm_no_data got %h want 0", bus.load_data); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rm_idle got %b want 0", bus.stall); end
    drive_req(2'b00, 3'b001, 1'b1, 32'h6002, 32'h0);
    tick();
    idle_req();
    bus.dmem_gnt = 1'b1;
    checks++; if (bus.dmem_req !== 1'b1) begin errors++; $display("FAIL rm_next_req got %b want 1", bus.dmem_req); end
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h0000_4321;
    tick();
    bus.dmem_rvalid = 1'b0;
    checks++; if (bus.load_valid !== 1'b1) begin errors++; $display("FAIL rm_next_valid got %b want 1", bus.load_valid); end
    checks++; if (bus.load_data !== 32'h00004321) begin errors++; $display("FAIL rm_next_data got %h want 00004321", bus.load_data); end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.MemWrite    = 2'b00;
    bus.Mask        = 3'b000;
    bus.is_load     = 1'b0;
    bus.addr        = 32'h0;
    bus.store_data  = 32'h0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_store();
    test_load_extend();
    test_misalign();
    test_back_to_back();
    test_noop();
    test_delayed_grant();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
